// File: rtl/exe_mem_reg.sv
// EXE -> MEM pipeline register with freeze/flush handling, new-request strobe
// and sticky protocol error. Optional perf counters enabled by EXE_MEM_PERF_EN.
module exe_mem_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [DEST_W-1:0] dest_in,
    output logic              valid,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] val_rm,
    output logic [DEST_W-1:0] dest,
    output logic              mem_req_new,
    output logic              exe_stall,
    output logic              proto_err,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       mem_ops
);

    logic              valid_q, valid_d;
    logic              wb_en_q, wb_en_d;
    logic              mem_r_en_q, mem_r_en_d;
    logic              mem_w_en_q, mem_w_en_d;
    logic [DATA_W-1:0] alu_res_q, alu_res_d;
    logic [DATA_W-1:0] val_rm_q, val_rm_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic              mem_req_new_q, mem_req_new_d;
    logic              proto_err_q, proto_err_d;

    // Priority: freeze holds everything, then bubble (flush or invalid), then load.
    always_comb begin
        valid_d       = valid_q;
        wb_en_d       = wb_en_q;
        mem_r_en_d    = mem_r_en_q;
        mem_w_en_d    = mem_w_en_q;
        alu_res_d     = alu_res_q;
        val_rm_d      = val_rm_q;
        dest_d        = dest_q;
        mem_req_new_d = 1'b0;
        proto_err_d   = proto_err_q;
        if (!freeze) begin
            alu_res_d = alu_res_in;
            val_rm_d  = val_rm_in;
            dest_d    = dest_in;
            if (flush || !valid_in) begin
                valid_d    = 1'b0;
                wb_en_d    = 1'b0;
                mem_r_en_d = 1'b0;
                mem_w_en_d = 1'b0;
            end else begin
                valid_d       = 1'b1;
                wb_en_d       = wb_en_in;
                // A simultaneous read+write request is illegal; the write wins.
                mem_w_en_d    = mem_w_en_in;
                mem_r_en_d    = mem_r_en_in & ~mem_w_en_in;
                mem_req_new_d = mem_r_en_in | mem_w_en_in;
                if (mem_r_en_in && mem_w_en_in) begin
                    proto_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q       <= 1'b0;
            wb_en_q       <= 1'b0;
            mem_r_en_q    <= 1'b0;
            mem_w_en_q    <= 1'b0;
            alu_res_q     <= '0;
            val_rm_q      <= '0;
            dest_q        <= '0;
            mem_req_new_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            wb_en_q       <= wb_en_d;
            mem_r_en_q    <= mem_r_en_d;
            mem_w_en_q    <= mem_w_en_d;
            alu_res_q     <= alu_res_d;
            val_rm_q      <= val_rm_d;
            dest_q        <= dest_d;
            mem_req_new_q <= mem_req_new_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign valid       = valid_q;
    assign wb_en       = wb_en_q;
    assign mem_r_en    = mem_r_en_q;
    assign mem_w_en    = mem_w_en_q;
    assign alu_res     = alu_res_q;
    assign val_rm      = val_rm_q;
    assign dest        = dest_q;
    assign mem_req_new = mem_req_new_q;
    assign proto_err   = proto_err_q;
    assign exe_stall   = freeze & valid_q;

`ifdef EXE_MEM_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] mem_ops_q, mem_ops_d;

    // Stall counter saturates; op counter wraps.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        mem_ops_d      = mem_ops_q;
        if (freeze && valid_q && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (mem_req_new_q) begin
            mem_ops_d = mem_ops_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            mem_ops_q      <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            mem_ops_q      <= mem_ops_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign mem_ops      = mem_ops_q;
`else
    assign stall_cycles = 32'd0;
    assign mem_ops      = 16'd0;
`endif

endmodule

// File: tb/tb_exe_mem_reg.sv
// Self-checking bench for exe_mem_reg: directed vector table plus
// hand-written multi-cycle sequences (freeze, proto_err, back-to-back, async reset).
module tb_exe_mem_reg;

   localparam bit PERF =
`ifdef EXE_MEM_PERF_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        flush;
   logic        valid_in;
   logic        wb_en_in;
   logic        mem_r_en_in;
   logic        mem_w_en_in;
   logic [31:0] alu_res_in;
   logic [31:0] val_rm_in;
   logic [3:0]  dest_in;
   logic        valid;
   logic        wb_en;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] alu_res;
   logic [31:0] val_rm;
   logic [3:0]  dest;
   logic        mem_req_new;
   logic        exe_stall;
   logic        proto_err;
   logic [31:0] stall_cycles;
   logic [15:0] mem_ops;

   int checks;
   int failures;

   typedef struct {
      logic        fr, fl, vi, wbi, mri, mwi;
      logic [31:0] alui, rmi;
      logic [3:0]  desti;
      logic        e_valid, e_wb, e_mr, e_mw;
      logic [31:0] e_alu, e_rm;
      logic [3:0]  e_dest;
      logic        e_req, e_stall, e_perr;
   } vec_t;

   vec_t vecs[8];

   exe_mem_reg #(.DATA_W(32), .DEST_W(4)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
      .valid(valid), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .alu_res(alu_res), .val_rm(val_rm), .dest(dest), .mem_req_new(mem_req_new),
      .exe_stall(exe_stall), .proto_err(proto_err), .stall_cycles(stall_cycles),
      .mem_ops(mem_ops)
   );

   // 10-unit clock period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fr, input logic fl, input logic vi, input logic wbi,
                        input logic mri, input logic mwi, input logic [31:0] alui,
                        input logic [31:0] rmi, input logic [3:0] desti);
      freeze = fr; flush = fl; valid_in = vi; wb_en_in = wbi;
      mem_r_en_in = mri; mem_w_en_in = mwi;
      alu_res_in = alui; val_rm_in = rmi; dest_in = desti;
   endtask

   task automatic applyStimulus(input vec_t v);
      drive(v.fr, v.fl, v.vi, v.wbi, v.mri, v.mwi, v.alui, v.rmi, v.desti);
   endtask

   task automatic checkOutput(input string tag, input vec_t v);
      checkField({tag, ".valid"},       valid,       v.e_valid);
      checkField({tag, ".wb_en"},       wb_en,       v.e_wb);
      checkField({tag, ".mem_r_en"},    mem_r_en,    v.e_mr);
      checkField({tag, ".mem_w_en"},    mem_w_en,    v.e_mw);
      checkField({tag, ".alu_res"},     alu_res,     v.e_alu);
      checkField({tag, ".val_rm"},      val_rm,      v.e_rm);
      checkField({tag, ".dest"},        dest,        v.e_dest);
      checkField({tag, ".mem_req_new"}, mem_req_new, v.e_req);
      checkField({tag, ".exe_stall"},   exe_stall,   v.e_stall);
      checkField({tag, ".proto_err"},   proto_err,   v.e_perr);
   endtask

   task automatic checkAllZero(input string tag);
      checkField({tag, ".valid"},        valid,        0);
      checkField({tag, ".wb_en"},        wb_en,        0);
      checkField({tag, ".mem_r_en"},     mem_r_en,     0);
      checkField({tag, ".mem_w_en"},     mem_w_en,     0);
      checkField({tag, ".alu_res"},      alu_res,      0);
      checkField({tag, ".val_rm"},       val_rm,       0);
      checkField({tag, ".dest"},         dest,         0);
      checkField({tag, ".mem_req_new"},  mem_req_new,  0);
      checkField({tag, ".proto_err"},    proto_err,    0);
      checkField({tag, ".stall_cycles"}, stall_cycles, 0);
      checkField({tag, ".mem_ops"},      mem_ops,      0);
   endtask

   // Reset asserted away from a clock edge, released on a falling edge
   task automatic doReset(input string tag);
      drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      rst = 1'b0;
      #2;
      checkAllZero(tag);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);

      //          fr fl vi wb mr mw alu_in        rm_in         dst   v  wb mr mw alu           rm            dst   req st perr
      vecs[0] = '{0, 0, 1, 1, 1, 0, 32'h0000_0040, 32'h0,        4'h3, 1, 1, 1, 0, 32'h0000_0040, 32'h0,        4'h3, 1, 0, 0};
      vecs[1] = '{0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        4'h0, 0, 0, 0, 0, 32'h0,         32'h0,        4'h0, 0, 0, 0};
      vecs[2] = '{0, 0, 1, 0, 0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h5, 1, 0, 0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h5, 1, 0, 0};
      vecs[3] = '{1, 0, 1, 1, 1, 0, 32'h0000_0200, 32'h1111_1111, 4'h7, 1, 0, 0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h5, 0, 1, 0};
      vecs[4] = '{1, 1, 1, 1, 1, 0, 32'h0000_0200, 32'h1111_1111, 4'h7, 1, 0, 0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h5, 0, 1, 0};
      vecs[5] = '{0, 1, 1, 1, 1, 0, 32'h0000_0300, 32'h2222_2222, 4'h9, 0, 0, 0, 0, 32'h0000_0300, 32'h2222_2222, 4'h9, 0, 0, 0};
      vecs[6] = '{0, 0, 1, 1, 0, 0, 32'h1234_5678, 32'h0,        4'hA, 1, 1, 0, 0, 32'h1234_5678, 32'h0,        4'hA, 0, 0, 0};
      vecs[7] = '{0, 0, 1, 0, 1, 1, 32'h0000_0080, 32'h0000_0055, 4'h2, 1, 0, 0, 1, 32'h0000_0080, 32'h0000_0055, 4'h2, 1, 0, 1};

      doReset("reset0");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput($sformatf("vec%0d", i), vecs[i]);
      end

      // Store latched, then five frozen cycles with changing inputs
      doReset("reset1");
      drive(0, 0, 1, 0, 0, 1, 32'h0000_0100, 32'h0000_CAFE, 4'h6);
      tick();
      checkField("frz.req_first", mem_req_new, 1);
      drive(1, 0, 1, 1, 1, 0, 32'h0000_0999, 32'h0000_1234, 4'hF);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkField($sformatf("frz%0d.valid", i),     valid,       1);
         checkField($sformatf("frz%0d.mem_w_en", i),  mem_w_en,    1);
         checkField($sformatf("frz%0d.mem_r_en", i),  mem_r_en,    0);
         checkField($sformatf("frz%0d.alu_res", i),   alu_res,     32'h0000_0100);
         checkField($sformatf("frz%0d.val_rm", i),    val_rm,      32'h0000_CAFE);
         checkField($sformatf("frz%0d.dest", i),      dest,        4'h6);
         checkField($sformatf("frz%0d.req", i),       mem_req_new, 0);
         checkField($sformatf("frz%0d.exe_stall", i), exe_stall,   1);
      end
      checkField("frz.stall_cycles", stall_cycles, PERF ? 32'd5 : 32'd0);
      checkField("frz.mem_ops",      mem_ops,      PERF ? 32'd1 : 32'd0);

      // Sticky protocol error survives normal traffic, clears only on reset
      doReset("reset2");
      drive(0, 0, 1, 0, 1, 1, 32'h0000_0044, 32'h0000_0077, 4'h1);
      tick();
      checkField("perr.mem_w_en",  mem_w_en,  1);
      checkField("perr.mem_r_en",  mem_r_en,  0);
      checkField("perr.proto_err", proto_err, 1);
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, (i % 2) == 0, 1, (i % 3) == 0, 0, 32'(i), 32'h0, 4'(i));
         tick();
      end
      checkField("perr.sticky", proto_err, 1);
      doReset("reset3");

      // Back-to-back memory ops
      drive(0, 0, 1, 1, 1, 0, 32'h0000_0010, 32'h0, 4'h1);
      tick();
      checkField("b2b0.req", mem_req_new, 1);
      drive(0, 0, 1, 0, 0, 1, 32'h0000_0014, 32'h0000_00AA, 4'h2);
      tick();
      checkField("b2b1.req", mem_req_new, 1);
      drive(0, 0, 1, 1, 1, 0, 32'h0000_0018, 32'h0, 4'h3);
      tick();
      checkField("b2b2.req", mem_req_new, 1);
      drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
      tick();
      checkField("b2b3.req",     mem_req_new, 0);
      checkField("b2b.mem_ops",  mem_ops,     PERF ? 32'd3 : 32'd0);

      // Asynchronous reset in the middle of a frozen read
      drive(0, 0, 1, 1, 1, 0, 32'h0000_0020, 32'h0, 4'h4);
      tick();
      drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
      tick();
      checkField("arst.held_mem_r_en", mem_r_en, 1);
      #2;
      rst = 1'b0;
      #1;
      checkAllZero("arst");
      checkField("arst.exe_stall", exe_stall, 0);
      drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 1, 1, 1, 0, 32'h0000_0040, 32'h0, 4'h3);
      tick();
      checkOutput("post_rst", vecs[0]);
      drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
      tick();
      checkField("post_rst.req_idle", mem_req_new, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
